// File: rtl/cl_video_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cl_video_pattern_gen: multi-tap CameraLink test-pattern source with      |
// | LVAL/FVAL/DVAL framing and run-time geometry.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
module cl_video_pattern_gen #(
  parameter int NUM_TAPS = 2,
  parameter int PIX_W    = 12,
  parameter int DIM_W    = 16,
  parameter int HB_W     = 8
) (
  input  logic                      pixel_clk,
  input  logic                      sys_rst,
  input  logic                      enable,
  input  logic                      single_shot,
  input  logic [1:0]                mode,
  input  logic [DIM_W-1:0]          img_width,
  input  logic [DIM_W-1:0]          img_height,
  input  logic [HB_W-1:0]           hblank,
  input  logic [DIM_W-1:0]          vblank,
  output logic [NUM_TAPS*PIX_W-1:0] tap_data,
  output logic                      lval,
  output logic                      fval,
  output logic                      dval,
  output logic [15:0]               frame_cnt,
  output logic                      busy,
  output logic                      cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FSETUP = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_e;

  state_e                    state_q;
  logic [DIM_W-1:0]          width_q, height_q, vb_q, x_q, y_q, cnt_q;
  logic [HB_W-1:0]           hb_q;
  logic [1:0]                mode_q;
  logic                      ss_q, wait_low_q;
  logic [15:0]               fc_q, frame_cnt_q;
  logic [NUM_TAPS*PIX_W-1:0] tap_q;
  logic                      lval_q, fval_q, busy_q, cfg_err_q;

  logic             w_cfg_ok, w_last_beat, w_last_line, w_hb_done, w_vb_done, w_relatch;
  logic [DIM_W-1:0] w_hb_eff, w_vb_eff, w_x_next;

  function automatic logic [NUM_TAPS*PIX_W-1:0] pix_beat(
    input logic [DIM_W-1:0] xb,
    input logic [DIM_W-1:0] y,
    input logic [1:0]       m,
    input logic [15:0]      fc
  );
    logic [NUM_TAPS*PIX_W-1:0] r;
    logic [DIM_W-1:0]          x;
    r = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      x = xb + DIM_W'(t);
      case (m)
        2'd0:    r[t*PIX_W +: PIX_W] = PIX_W'(x);
        2'd1:    r[t*PIX_W +: PIX_W] = PIX_W'(y);
        2'd2:    r[t*PIX_W +: PIX_W] = (x[3] ^ y[3]) ? {PIX_W{1'b1}} : '0;
        default: r[t*PIX_W +: PIX_W] = PIX_W'(x + y + DIM_W'(fc));
      endcase
    end
    return r;
  endfunction

  assign w_cfg_ok    = (img_width != '0) && ((img_width % DIM_W'(NUM_TAPS)) == '0)
                       && (img_height != '0);
  assign w_x_next    = x_q + DIM_W'(NUM_TAPS);
  assign w_last_beat = (w_x_next == width_q);
  assign w_last_line = (y_q == height_q - DIM_W'(1));
  assign w_hb_eff    = (hb_q == '0) ? DIM_W'(1) : DIM_W'(hb_q);
  assign w_vb_eff    = (vb_q == '0) ? DIM_W'(1) : vb_q;
  assign w_hb_done   = (cnt_q >= w_hb_eff);
  assign w_vb_done   = (cnt_q >= w_vb_eff);
  // Latch points: a fresh start from IDLE, or the end of VBLANK in continuous mode.
  assign w_relatch   = enable && (((state_q == S_IDLE) && !wait_low_q) ||
                                  ((state_q == S_VBLANK) && w_vb_done && !ss_q));

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      vb_q        <= '0;
      hb_q        <= '0;
      mode_q      <= '0;
      ss_q        <= 1'b0;
      wait_low_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      fc_q        <= '0;
      frame_cnt_q <= '0;
      tap_q       <= '0;
      lval_q      <= 1'b0;
      fval_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          lval_q <= 1'b0;
          fval_q <= 1'b0;
          tap_q  <= '0;
          busy_q <= 1'b0;
          if (!enable) begin
            cfg_err_q  <= 1'b0;
            wait_low_q <= 1'b0;
          end
        end
        S_FSETUP: begin
          state_q <= S_LINE;
          lval_q  <= 1'b1;
          tap_q   <= pix_beat('0, y_q, mode_q, fc_q);
        end
        S_LINE: begin
          if (!w_last_beat) begin
            x_q   <= w_x_next;
            tap_q <= pix_beat(w_x_next, y_q, mode_q, fc_q);
          end else begin
            lval_q <= 1'b0;
            tap_q  <= '0;
            cnt_q  <= DIM_W'(1);
            if (w_last_line) begin
              state_q     <= S_VBLANK;
              fval_q      <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              state_q <= S_HBLANK;
              y_q     <= y_q + DIM_W'(1);
            end
          end
        end
        S_HBLANK: begin
          if (w_hb_done) begin
            state_q <= S_LINE;
            lval_q  <= 1'b1;
            x_q     <= '0;
            tap_q   <= pix_beat('0, y_q, mode_q, fc_q);
          end else begin
            cnt_q <= cnt_q + DIM_W'(1);
          end
        end
        S_VBLANK: begin
          if (w_vb_done) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            wait_low_q <= ss_q;
          end else begin
            cnt_q <= cnt_q + DIM_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Overrides the per-state defaults above when a new frame is requested.
      if (w_relatch) begin
        width_q  <= img_width;
        height_q <= img_height;
        hb_q     <= hblank;
        vb_q     <= vblank;
        mode_q   <= mode;
        ss_q     <= single_shot;
        if (w_cfg_ok) begin
          state_q    <= S_FSETUP;
          fval_q     <= 1'b1;
          busy_q     <= 1'b1;
          wait_low_q <= 1'b0;
          x_q        <= '0;
          y_q        <= '0;
          fc_q       <= frame_cnt_q;
        end else begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          cfg_err_q  <= 1'b1;
          wait_low_q <= 1'b1;
        end
      end
    end
  end

  assign tap_data  = tap_q;
  assign lval      = lval_q;
  assign dval      = lval_q;
  assign fval      = fval_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cl_video_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cl_video_pattern_gen: directed bench for cl_video_pattern_gen.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cl_video_pattern_gen;
  localparam int NT = 2;
  localparam int PW = 12;
  localparam int DW = 16;
  localparam int HW = 8;

  logic            pixel_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            enable = 1'b0;
  logic            en8 = 1'b0;
  logic            single_shot = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [DW-1:0]   img_width = 16'd8, img_height = 16'd3, vblank = 16'd4;
  logic [HW-1:0]   hblank = 8'd2;
  logic [NT*PW-1:0] tap_data;
  logic            lval, fval, dval, busy, cfg_err;
  logic [15:0]     frame_cnt;
  logic [NT*8-1:0] tap8;
  logic            lval8, fval8, dval8, busy8, cfg_err8;
  logic [15:0]     fcnt8;

  int   checks = 0;
  int   errors = 0;
  int   frame_viol = 0;
  logic prev_fval = 1'b0, prev_lval = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  cl_video_pattern_gen #(.NUM_TAPS(NT), .PIX_W(PW), .DIM_W(DW), .HB_W(HW)) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(enable), .single_shot(single_shot),
    .mode(mode), .img_width(img_width), .img_height(img_height), .hblank(hblank),
    .vblank(vblank), .tap_data(tap_data), .lval(lval), .fval(fval), .dval(dval),
    .frame_cnt(frame_cnt), .busy(busy), .cfg_err(cfg_err)
  );

  cl_video_pattern_gen #(.NUM_TAPS(NT), .PIX_W(8), .DIM_W(DW), .HB_W(HW)) dut8 (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(en8), .single_shot(single_shot),
    .mode(mode), .img_width(img_width), .img_height(img_height), .hblank(hblank),
    .vblank(vblank), .tap_data(tap8), .lval(lval8), .fval(fval8), .dval(dval8),
    .frame_cnt(fcnt8), .busy(busy8), .cfg_err(cfg_err8)
  );

  task automatic step();
    prev_fval = fval;
    prev_lval = lval;
    @(posedge pixel_clk);
    #1;
    if (dval !== lval || (!lval && tap_data !== '0) || dval8 !== lval8) frame_viol++;
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    en8     = 1'b0;
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic setup(input int w, input int h, input int hb, input int vb,
                       input int m, input bit ss);
    img_width   = DW'(w);
    img_height  = DW'(h);
    hblank      = HW'(hb);
    vblank      = DW'(vb);
    mode        = 2'(m);
    single_shot = ss;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step();
    checks++;
    if ({lval, fval, dval, busy, cfg_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {lval, fval, dval, busy, cfg_err});
    end
    checks++;
    if (tap_data !== '0) begin errors++; $display("FAIL reset_tap got %h want 0", tap_data); end
    checks++;
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
    sys_rst = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || fval !== 1'b0) begin
      errors++; $display("FAIL idle_no_enable got busy=%b fval=%b want 0 0", busy, fval);
    end
  endtask

  task automatic test_single_shot();
    int nf = 0, nl = 0, beat = 0, first_f = -1, first_l = -1, vb_busy = 0, nrise = 0, x0;
    do_reset();
    setup(8, 3, 2, 4, 0, 1'b1);
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (fval) begin nf++; if (first_f < 0) first_f = c; end
      if (fval && !prev_fval) nrise++;
      if (lval) begin
        if (first_l < 0) first_l = c;
        if (!prev_lval) nl++;
        x0 = 2 * (beat % 4);
        checks++;
        if (tap_data !== {PW'(x0 + 1), PW'(x0)}) begin
          errors++; $display("FAIL ss_beat%0d got %h want %h", beat, tap_data, {PW'(x0 + 1), PW'(x0)});
        end
        if (beat == 11) begin
          checks++;
          if (frame_cnt !== 16'd0) begin errors++; $display("FAIL ss_fcnt_last got %0d want 0", frame_cnt); end
        end
        beat++;
      end
      if (!fval && prev_fval) begin
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ss_fcnt_fall got %0d want 1", frame_cnt); end
      end
      if (busy && !fval && nf > 0) vb_busy++;
    end
    checks++; if (nf != 17) begin errors++; $display("FAIL ss_fval_len got %0d want 17", nf); end
    checks++; if (nl != 3) begin errors++; $display("FAIL ss_lines got %0d want 3", nl); end
    checks++; if (beat != 12) begin errors++; $display("FAIL ss_beats got %0d want 12", beat); end
    checks++;
    if (first_l != first_f + 1) begin
      errors++; $display("FAIL ss_lval_lag got %0d want %0d", first_l, first_f + 1);
    end
    checks++; if (vb_busy != 4) begin errors++; $display("FAIL ss_vblank got %0d want 4", vb_busy); end
    checks++; if (nrise != 1) begin errors++; $display("FAIL ss_one_frame got %0d want 1", nrise); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy_end got %b want 0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_continuous();
    int rise[4];
    int nrise = 0, lines = 0, nfall = 0, f3 = 0;
    rise = '{default: 0};
    do_reset();
    setup(8, 3, 2, 4, 0, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 150; c++) begin
      step();
      if (fval && !prev_fval) begin
        if (nrise < 4) rise[nrise] = c;
        nrise++;
        lines = 0;
      end
      if (lval && !prev_lval) begin
        lines++;
        if (nrise == 3 && lines == 2) enable = 1'b0;
      end
      if (nrise == 3 && fval) f3++;
      if (!fval && prev_fval) begin
        nfall++;
        checks++;
        if (frame_cnt !== 16'(nfall)) begin
          errors++; $display("FAIL cont_fcnt got %0d want %0d", frame_cnt, nfall);
        end
      end
    end
    checks++; if (nrise != 3) begin errors++; $display("FAIL cont_frames got %0d want 3", nrise); end
    checks++;
    if (rise[1] - rise[0] != 21) begin errors++; $display("FAIL cont_period1 got %0d want 21", rise[1] - rise[0]); end
    checks++;
    if (rise[2] - rise[1] != 21) begin errors++; $display("FAIL cont_period2 got %0d want 21", rise[2] - rise[1]); end
    checks++; if (f3 != 17) begin errors++; $display("FAIL cont_last_len got %0d want 17", f3); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL cont_fcnt_end got %0d want 3", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end got %b want 0", busy); end
  endtask

  task automatic test_cfg_err();
    int nf = 0, lines = 0;
    do_reset();
    setup(7, 3, 2, 4, 1, 1'b1);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (fval) nf++;
    end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got %b want 1", cfg_err); end
    checks++; if (nf != 0) begin errors++; $display("FAIL cfg_no_fval got %0d want 0", nf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy got %b want 0", busy); end
    enable = 1'b0;
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got %b want 0", cfg_err); end
    img_width = 16'd8;
    enable = 1'b1;
    nf = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (fval) nf++;
      if (lval && !prev_lval) begin
        lines++;
        if (lines == 3) begin
          checks++;
          if (tap_data !== {PW'(2), PW'(2)}) begin
            errors++; $display("FAIL vramp_line2 got %h want %h", tap_data, {PW'(2), PW'(2)});
          end
        end
      end
    end
    checks++; if (nf != 17) begin errors++; $display("FAIL cfg_frame_len got %0d want 17", nf); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_run got %b want 0", cfg_err); end
    enable = 1'b0;
  endtask

  task automatic test_checker();
    int lines = 0, beat = 0, y;
    logic [NT*PW-1:0] exp_v;
    do_reset();
    setup(32, 9, 1, 1, 2, 1'b1);
    enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (lval) begin
        if (!prev_lval) begin lines++; beat = 0; end
        y = lines - 1;
        if ((y == 0 || y == 8) && beat < 8) begin
          exp_v = (((beat / 4) ^ (y / 8)) & 1) != 0 ? 24'hFFF_FFF : 24'h000_000;
          checks++;
          if (tap_data !== exp_v) begin
            errors++; $display("FAIL checker_y%0d_b%0d got %h want %h", y, beat, tap_data, exp_v);
          end
        end
        beat++;
      end
    end
    checks++; if (lines != 9) begin errors++; $display("FAIL checker_lines got %0d want 9", lines); end
    enable = 1'b0;
  endtask

  task automatic test_wrap_hblank0();
    int nf = 0, lines = 0, beat = 0, gap = 0;
    logic p8 = 1'b0;
    do_reset();
    setup(512, 2, 0, 1, 0, 1'b1);
    en8 = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      step();
      if (fval8) nf++;
      if (lval8) begin
        if (!p8) begin lines++; beat = 0; end
        if (lines == 1 && beat == 127) begin
          checks++;
          if (tap8 !== 16'hFFFE) begin errors++; $display("FAIL wrap_x254 got %h want fffe", tap8); end
        end
        if (lines == 1 && beat == 128) begin
          checks++;
          if (tap8 !== 16'h0100) begin errors++; $display("FAIL wrap_x256 got %h want 0100", tap8); end
        end
        beat++;
      end else if (fval8 && lines >= 1) begin
        gap++;
      end
      p8 = lval8;
    end
    checks++; if (gap != 1) begin errors++; $display("FAIL hb0_gap got %0d want 1", gap); end
    checks++; if (lines != 2) begin errors++; $display("FAIL hb0_lines got %0d want 2", lines); end
    checks++; if (nf != 514) begin errors++; $display("FAIL hb0_fval_len got %0d want 514", nf); end
    en8 = 1'b0;
  endtask

  task automatic test_reset_midline();
    int  nrise = 0, beat = 0, lines = 0;
    bit  hit = 1'b0;
    do_reset();
    setup(8, 3, 2, 4, 3, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      step();
      if (fval && !prev_fval) begin nrise++; beat = 0; end
      if (lval && nrise == 2) begin
        if (beat == 0) begin
          checks++;
          if (tap_data !== {PW'(2), PW'(1)}) begin
            errors++; $display("FAIL diag_fc1 got %h want %h", tap_data, {PW'(2), PW'(1)});
          end
        end
        if (beat == 2) begin
          checks++;
          if (tap_data !== {PW'(6), PW'(5)}) begin
            errors++; $display("FAIL diag_beat2 got %h want %h", tap_data, {PW'(6), PW'(5)});
          end
          hit = 1'b1;
        end
        beat++;
      end
    end
    if (!hit) begin
      checks++; errors++; $display("FAIL rst_reach_beat2 got timeout want beat 2 of frame 2");
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({lval, fval, dval, busy} !== 4'b0) begin
      errors++; $display("FAIL async_rst_ctrl got %b want 0000", {lval, fval, dval, busy});
    end
    checks++; if (tap_data !== '0) begin errors++; $display("FAIL async_rst_tap got %h want 0", tap_data); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_fcnt got %0d want 0", frame_cnt); end
    @(posedge pixel_clk);
    #1 sys_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (lval && !prev_lval) begin
        lines++;
        if (lines <= 2) begin
          checks++;
          if (tap_data !== {PW'(lines), PW'(lines - 1)}) begin
            errors++; $display("FAIL restart_line%0d got %h want %h", lines - 1, tap_data,
                                {PW'(lines), PW'(lines - 1)});
          end
        end
      end
    end
    checks++; if (lines < 2) begin errors++; $display("FAIL restart_lines got %0d want >=2", lines); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_cfg_err();
    test_checker();
    test_wrap_hblank0();
    test_reset_midline();
    checks++;
    if (frame_viol != 0) begin
      errors++; $display("FAIL framing_invariant got %0d violations want 0", frame_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
